// File: rtl/switch_allocator.sv
// switch_allocator: per-router switch allocator.
// Each output port has its own IDLE/LOCKED FSM. In IDLE it picks the first
// requester for that output, scanning round-robin from rr_ptr. In LOCKED it
// keeps the chosen input as owner from the head flit to the tail flit.
//
// State table (per output):
//   state  | meaning
//   IDLE   | output free; arbitrating among requesters for this output
//   LOCKED | output owned by owner[o]; crossbar select held until release
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-input flit-ready request
//   req_dest   per-input requested output (SEL_WIDTH bits each)
//   req_tail   per-input: offered flit is a tail flit
//   out_ready  per-output downstream ready
//   grant      per-input grant (input owns some output)
//   sel        per-output crossbar select (owning input index)
//   sel_valid  per-output: output is owned
//   overrun    one-cycle pulse when a lock is force-released by length limit
module switch_allocator #(
  parameter int NUM_PORTS       = 5,
  parameter int MAX_PACKET_SIZE = 64,
  localparam int SEL_WIDTH      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]           req_tail,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS*SEL_WIDTH-1:0] sel,
  output logic [NUM_PORTS-1:0]           sel_valid,
  output logic                           overrun
);

  localparam int CNT_W = $clog2(MAX_PACKET_SIZE + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q [NUM_PORTS];
  logic [SEL_WIDTH-1:0]   owner_q [NUM_PORTS];
  logic [SEL_WIDTH-1:0]   rr_q    [NUM_PORTS];
  logic [CNT_W-1:0]       cnt_q   [NUM_PORTS];
  logic                   overrun_q;

  logic                   win_found [NUM_PORTS];
  logic [SEL_WIDTH-1:0]   win_idx   [NUM_PORTS];
  logic                   xfer      [NUM_PORTS];
  logic                   rel       [NUM_PORTS];
  logic                   force_rel [NUM_PORTS];
  logic [CNT_W-1:0]       cnt_nxt   [NUM_PORTS];

  // An input owns at most one output, so grant is a plain OR of ownership.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == LOCKED) grant[owner_q[o]] = 1'b1;
    end
  end

  // Round-robin scan from rr_q. Inputs already owning an output are masked
  // so a misbehaving input that changes destination mid-packet can never
  // hold two outputs at once.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_found[o] = 1'b0;
      win_idx[o]   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        int idx;
        idx = int'(rr_q[o]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!win_found[o] && req[idx] && !grant[idx] &&
            (req_dest[idx*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(o))) begin
          win_found[o] = 1'b1;
          win_idx[o]   = SEL_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      xfer[o]      = (state_q[o] == LOCKED) && req[owner_q[o]] && out_ready[o];
      cnt_nxt[o]   = cnt_q[o] + 1'b1;
      rel[o]       = xfer[o] && (req_tail[owner_q[o]] ||
                                 (cnt_nxt[o] == CNT_W'(MAX_PACKET_SIZE)));
      force_rel[o] = xfer[o] && !req_tail[owner_q[o]] &&
                     (cnt_nxt[o] == CNT_W'(MAX_PACKET_SIZE));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cnt_q[o]   <= '0;
      end
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (state_q[o])
          IDLE: begin
            if (win_found[o]) begin
              state_q[o] <= LOCKED;
              owner_q[o] <= win_idx[o];
              cnt_q[o]   <= '0;
            end
          end
          LOCKED: begin
            if (xfer[o]) cnt_q[o] <= cnt_nxt[o];
            if (rel[o]) begin
              state_q[o] <= IDLE;
              // Pointer moves past the releasing owner so waiting inputs win first.
              rr_q[o] <= (owner_q[o] == SEL_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                  : owner_q[o] + 1'b1;
            end
            if (force_rel[o]) overrun_q <= 1'b1;
          end
          default: state_q[o] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      sel[o*SEL_WIDTH +: SEL_WIDTH] = owner_q[o];
      sel_valid[o]                  = (state_q[o] == LOCKED);
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

  localparam int NP = 5;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req;
  logic [NP*SW-1:0] req_dest;
  logic [NP-1:0]   req_tail;
  logic [NP-1:0]   out_ready;
  logic [NP-1:0]   grant;
  logic [NP*SW-1:0] sel;
  logic [NP-1:0]   sel_valid;
  logic            overrun;

  int checks   = 0;
  int failures = 0;

  switch_allocator #(.NUM_PORTS(NP), .MAX_PACKET_SIZE(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dest(req_dest), .req_tail(req_tail),
    .out_ready(out_ready), .grant(grant), .sel(sel), .sel_valid(sel_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int i, input int d);
    logic [SW-1:0] dv;
    dv = SW'(d);
    req_dest[i*SW +: SW] = dv;
  endtask

  function automatic logic [SW-1:0] sel_of(input int o);
    return sel[o*SW +: SW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with all inputs requesting
    rst = 1'b0; req = 5'b11111; req_dest = '0; req_tail = '0; out_ready = 5'b11111;
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // First grant one cycle after first sampled edge; 1-flit packet on output 0
    req = 5'b00001; req_tail = 5'b00001; set_dest(0, 0);
    rst = 1'b1;
    tick();
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_selv", 32'(sel_valid), 32'h01);
    tick();
    chk("first_release", 32'(grant), 0);
    req = '0; req_tail = '0;
    tick();

    // Single requester: input 2 -> output 3, 4-flit packet
    set_dest(2, 3); req = 5'b00100;
    tick();
    chk("single_grant", 32'(grant), 32'h04);
    chk("single_sel3", 32'(sel_of(3)), 2);
    chk("single_selv", 32'(sel_valid), 32'h08);
    for (int f = 1; f <= 3; f++) begin
      tick();
      chk("single_hold", 32'(grant), 32'h04);
    end
    req_tail = 5'b00100;
    tick();
    chk("single_release", 32'(grant), 0);
    chk("single_no_overrun", 32'(overrun), 0);
    req = '0; req_tail = '0;
    tick();

    // Contention: inputs 0,1,4 -> output 2, 1-flit packets
    set_dest(0, 2); set_dest(1, 2); set_dest(4, 2);
    req = 5'b10011; req_tail = 5'b10011;
    tick(); chk("cont_g0", 32'(grant), 32'h01);
    chk("cont_sel2", 32'(sel_of(2)), 0);
    tick(); chk("cont_gap0", 32'(grant), 0);
    tick(); chk("cont_g1", 32'(grant), 32'h02);
    chk("cont_sel2b", 32'(sel_of(2)), 1);
    tick(); chk("cont_gap1", 32'(grant), 0);
    tick(); chk("cont_g4", 32'(grant), 32'h10);
    tick(); chk("cont_gap4", 32'(grant), 0);
    tick(); chk("cont_g0b", 32'(grant), 32'h01);
    req = 5'b00001; req_tail = 5'b00001;
    tick(); chk("cont_end", 32'(grant), 0);
    req = '0; req_tail = '0;
    tick();

    // Backpressure: input 1 owns output 0, input 3 waits
    set_dest(1, 0); set_dest(3, 0);
    req = 5'b01010; req_tail = 5'b00010; out_ready = 5'b11110;
    tick(); chk("bp_grant", 32'(grant), 32'h02);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold", 32'(grant), 32'h02);
      chk("bp_selv", 32'(sel_valid), 32'h01);
    end
    out_ready = 5'b11111;
    tick(); chk("bp_release", 32'(grant), 0);
    tick(); chk("bp_next", 32'(grant), 32'h08);
    chk("bp_sel0", 32'(sel_of(0)), 3);
    req_tail = 5'b01010;
    tick(); chk("bp_end", 32'(grant), 0);
    req = '0; req_tail = '0;
    tick();

    // Parallel outputs: 0->1, 2->4
    set_dest(0, 1); set_dest(2, 4);
    req = 5'b00101;
    tick();
    chk("par_grant", 32'(grant), 32'h05);
    chk("par_selv", 32'(sel_valid), 32'h12);
    chk("par_sel1", 32'(sel_of(1)), 0);
    chk("par_sel4", 32'(sel_of(4)), 2);
    req_tail = 5'b00100;
    tick();
    chk("par_rel4", 32'(grant), 32'h01);
    chk("par_selv4", 32'(sel_valid), 32'h02);
    req = 5'b00001; req_tail = 5'b00001;
    tick();
    chk("par_rel1", 32'(grant), 0);
    req = '0; req_tail = '0;
    tick();

    // Overrun: input 3 -> output 2, non-tail flits with limit 4
    set_dest(3, 2); req = 5'b01000;
    tick(); chk("ovr_grant", 32'(grant), 32'h08);
    for (int f = 1; f <= 3; f++) begin
      tick();
      chk("ovr_hold", 32'(grant), 32'h08);
      chk("ovr_quiet", 32'(overrun), 0);
    end
    tick();
    chk("ovr_release", 32'(grant), 0);
    chk("ovr_pulse", 32'(overrun), 1);
    req = '0;
    tick();
    chk("ovr_pulse_end", 32'(overrun), 0);

    // Out-of-range destination is never granted
    set_dest(4, 7); req = 5'b10000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("oor_grant", 32'(grant), 0);
      chk("oor_selv", 32'(sel_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router switch allocator. Shares each router output port among the input Buffer_Units that request it.
- Issues a per-input grant and a per-output crossbar select.
- Arbitration is round-robin per output. Ownership is wormhole-locked from head flit to tail flit.
- Sits between the input buffers' ReqGnt switch-allocator interfaces and the crossbar mux selects.

Parameters:
- NUM_PORTS, 5, number of router input ports and output ports (local + N/E/S/W).
- MAX_PACKET_SIZE, 64, maximum flits per packet; a lock held longer than this is force-released.
- SEL_WIDTH (localparam), $clog2(NUM_PORTS), width of one destination or select field.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_PORTS  input i has a flit ready for switch traversal.
- req_dest  input  NUM_PORTS*SEL_WIDTH  field i holds the output port requested by input i.
- req_tail  input  NUM_PORTS  the flit currently offered by input i is a tail flit.
- out_ready  input  NUM_PORTS  downstream of output o can accept a flit this cycle.
- grant  output  NUM_PORTS  input i owns an output; equals the ReqGnt grant of input i.
- sel  output  NUM_PORTS*SEL_WIDTH  field o holds the input index driving output o.
- sel_valid  output  NUM_PORTS  output o is owned; the crossbar drives it.
- overrun  output  1  one-cycle pulse when any lock is force-released by the length limit.

Behaviour:
- Reset (rst=0, asynchronous): all outputs IDLE; grant=0, sel=0, sel_valid=0, overrun=0; every rr_ptr=0; every flit counter=0.
- Each output o has an independent FSM with two states, IDLE and LOCKED. Each holds a registered owner[o], rr_ptr[o] and flit_cnt[o].
- IDLE:
  - Candidates are inputs i with req[i]=1 and req_dest[i]==o.
  - The winner is the first candidate scanning from rr_ptr[o] upward, wrapping modulo NUM_PORTS.
  - If a winner exists, the next cycle is LOCKED with owner=winner, grant[winner]=1, sel[o]=winner, sel_valid[o]=1, flit_cnt=0.
  - Latency: grant is visible one cycle after the request is sampled.
- LOCKED:
  - A transfer occurs in a cycle where req[owner]=1 and out_ready[o]=1. On each transfer flit_cnt increments.
  - req[owner]=0 while locked does not release the lock; the output stays reserved and sel is held.
  - req_dest[owner] is ignored while locked. The input must not change destination mid-packet.
  - Release on tail: a transfer with req_tail[owner]=1 moves the FSM to IDLE next cycle. At that point grant[owner] clears, sel_valid[o] clears, rr_ptr[o]=(owner+1) mod NUM_PORTS.
  - The next grant on o appears no earlier than 2 cycles after the tail transfer cycle. The idle cycle is intentional.
  - Single-flit packet (head with req_tail=1) releases on its first transfer.
  - Forced release: a non-tail transfer that makes flit_cnt reach MAX_PACKET_SIZE releases exactly like a tail transfer and pulses overrun for 1 cycle.
- Grant uniqueness:
  - An input has one destination, so it wins at most one output.
  - grant[i] is the OR over outputs owned by i. At most one bit of the per-output ownership for input i is ever set.
- req_dest >= NUM_PORTS: the request is ignored; the input is never granted; no error is raised.
- A request for the same output from the current owner after its tail is treated as a new arbitration. The rr_ptr advance guarantees other waiting inputs win first.
- Simultaneous events: one output releasing while another grants in the same cycle is independent; no cross-output interaction.
- rr_ptr[o] changes only on release, never on grant.
- sel[o] holds its last value in IDLE (don't-care; sel_valid=0).

Test Plan:
- Reset: hold rst=0 with req=5'b11111 → grant=0, sel_valid=0. Release rst; the first grant appears on the cycle after the first sampled rising edge.
- Single requester: input 2, dest=3, out_ready=1, 4-flit packet with tail on flit 4 → grant[2]=1 one cycle after req. sel[3]=2. grant drops the cycle after the tail transfer.
- Contention: inputs 0, 1, 4 all request dest 2 with 1-flit packets → grant order 0, 1, 4, 0. Each grant follows the previous tail by 2 cycles.
- Backpressure: owner input 1 on output 0, out_ready[0]=0 for 5 cycles, while input 3 also requests 0 → lock held, grant[3]=0 throughout. Release occurs only after the tail is transferred with out_ready=1.
- Parallel outputs: input 0→1 and input 2→4 requested in the same cycle → both granted in the same cycle. Independent tails release independently.
- Overrun: MAX_PACKET_SIZE=4, owner sends 4 non-tail transfers → forced release after the 4th. overrun=1 for exactly 1 cycle. A subsequent out-of-range dest=7 is never granted.
